// File: rtl/motion_pkg.sv
// Shared definitions for the motion tracker: default sizes, heading encoding
// and the signed saturation helper used by each axis.
package motion_pkg;

    localparam int W_DEF     = 11;
    localparam int DW_DEF    = 4;
    localparam int STALL_DEF = 8;

    localparam logic HEAD_INC = 1'b1;
    localparam logic HEAD_DEC = 1'b0;

    // Clamp a signed value into the range representable by a dw-bit signed field.
    // The caller truncates the result to dw bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] delta,
                                                      input int                  dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] res;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (delta > hi) begin
            res = hi;
        end else if (delta < lo) begin
            res = lo;
        end else begin
            res = delta;
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_tracker.sv
// Single-axis tracker: remembers the previous position, and on each sample
// produces a saturated signed delta, a held heading and a one-cycle reversal
// pulse. is_zero flags a zero-motion sample combinationally for the stall logic.
module axis_tracker
    import motion_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 primed,
    input  logic [W-1:0]         pos,
    output logic                 heading,
    output logic signed [DW-1:0] delta_sat,
    output logic                 rev,
    output logic                 is_zero
);

    logic [W-1:0]         prev_q;
    logic [W-1:0]         prev_d;
    logic                 heading_q;
    logic                 heading_d;
    logic signed [DW-1:0] delta_q;
    logic signed [DW-1:0] delta_d;
    logic                 rev_q;
    logic                 rev_d;

    logic signed [W:0]    diff_s;
    logic signed [31:0]   diff_ext_s;
    logic                 zero_s;

    // Difference is taken one bit wider than the position so it can never wrap.
    always_comb begin
        diff_s     = $signed({1'b0, pos}) - $signed({1'b0, prev_q});
        diff_ext_s = {{(32 - W - 1){diff_s[W]}}, diff_s};
        zero_s     = (diff_s == {(W + 1){1'b0}});
    end

    // Next-state: first sample only captures the reference; later samples
    // update delta, heading and the reversal pulse. Rev clears on idle cycles.
    always_comb begin
        prev_d    = prev_q;
        heading_d = heading_q;
        delta_d   = delta_q;
        rev_d     = 1'b0;
        if (sample_en) begin
            if (!primed) begin
                prev_d = pos;
            end else begin
                prev_d  = pos;
                delta_d = DW'(sat_signed(diff_ext_s, DW));
                if (zero_s) begin
                    heading_d = heading_q;
                end else if (diff_s[W]) begin
                    heading_d = HEAD_DEC;
                end else begin
                    heading_d = HEAD_INC;
                end
                rev_d = (heading_d != heading_q);
            end
        end else begin
            rev_d = 1'b0;
        end
    end

    // Axis state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= {W{1'b0}};
            heading_q <= HEAD_INC;
            delta_q   <= {DW{1'b0}};
            rev_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            heading_q <= heading_d;
            delta_q   <= delta_d;
            rev_q     <= rev_d;
        end
    end

    assign heading   = heading_q;
    assign delta_sat = delta_q;
    assign rev       = rev_q;
    assign is_zero   = zero_s;

endmodule

// File: rtl/motion_tracker.sv
// Two-axis sprite motion tracker. Each axis runs its own heading/velocity
// tracker; the top owns the primed flag and the shared stall counter.
module motion_tracker
    import motion_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int DW           = DW_DEF,
    parameter int STALL_FRAMES = STALL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pos_valid,
    input  logic [W-1:0]         bx,
    input  logic [W-1:0]         by,
    output logic                 xh,
    output logic                 yh,
    output logic signed [DW-1:0] dx,
    output logic signed [DW-1:0] dy,
    output logic                 x_rev,
    output logic                 y_rev,
    output logic                 stalled,
    output logic                 primed
);

    localparam int            CW        = $clog2(STALL_FRAMES + 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_FRAMES);

    logic          primed_q;
    logic          primed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stalled_q;
    logic          stalled_d;
    logic          x_zero_s;
    logic          y_zero_s;

    axis_tracker #(.W(W), .DW(DW)) u_axis_x (
        .clk       (clk),
        .rst       (rst),
        .sample_en (pos_valid),
        .primed    (primed_q),
        .pos       (bx),
        .heading   (xh),
        .delta_sat (dx),
        .rev       (x_rev),
        .is_zero   (x_zero_s)
    );

    axis_tracker #(.W(W), .DW(DW)) u_axis_y (
        .clk       (clk),
        .rst       (rst),
        .sample_en (pos_valid),
        .primed    (primed_q),
        .pos       (by),
        .heading   (yh),
        .delta_sat (dy),
        .rev       (y_rev),
        .is_zero   (y_zero_s)
    );

    // Primed latches on the first sample; the stall count advances only on
    // primed samples with no motion on either axis and saturates at the limit.
    always_comb begin
        primed_d = primed_q;
        cnt_d    = cnt_q;
        if (pos_valid) begin
            primed_d = 1'b1;
            if (primed_q) begin
                if (x_zero_s && y_zero_s) begin
                    if (cnt_q == STALL_MAX) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = {CW{1'b0}};
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            primed_d = primed_q;
        end
        stalled_d = (cnt_d == STALL_MAX);
    end

    // Shared state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed_q  <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            stalled_q <= 1'b0;
        end else begin
            primed_q  <= primed_d;
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
        end
    end

    assign primed  = primed_q;
    assign stalled = stalled_q;

endmodule

// File: tb/tb_motion_tracker.sv
// Self-checking bench for motion_tracker: directed scenarios plus a random
// run, all checked against a plain-arithmetic reference model.
module tb_motion_tracker;

    localparam int STALL = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              pos_valid;
    logic [10:0]       bx;
    logic [10:0]       by;
    logic              xh;
    logic              yh;
    logic signed [3:0] dx;
    logic signed [3:0] dy;
    logic              x_rev;
    logic              y_rev;
    logic              stalled;
    logic              primed;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int mpx, mpy, mdx, mdy, mcnt;
    bit mprimed, mxh, myh, mxr, myr, mstall;

    motion_tracker #(.W(11), .DW(4), .STALL_FRAMES(STALL)) dut (
        .clk(clk), .rst(rst), .pos_valid(pos_valid), .bx(bx), .by(by),
        .xh(xh), .yh(yh), .dx(dx), .dy(dy), .x_rev(x_rev), .y_rev(y_rev),
        .stalled(stalled), .primed(primed)
    );

    always #5 clk = ~clk;

    function automatic int clampv(int v);
        if (v > 7) return 7;
        if (v < -8) return -8;
        return v;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [3:0] ex;
        logic [3:0] ey;
        ex = 4'(mdx);
        ey = 4'(mdy);
        return {mxh, myh, ex, ey, mxr, myr, mstall, mprimed};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {xh, yh, dx, dy, x_rev, y_rev, stalled, primed};
    endfunction

    task automatic m_reset();
        mpx = 0; mpy = 0; mdx = 0; mdy = 0; mcnt = 0;
        mprimed = 0; mxh = 1; myh = 1; mxr = 0; myr = 0; mstall = 0;
    endtask

    task automatic m_idle();
        mxr = 0; myr = 0;
    endtask

    task automatic m_sample(input int x, input int y);
        int ddx, ddy;
        bit nh;
        if (!mprimed) begin
            mpx = x; mpy = y; mprimed = 1; mxr = 0; myr = 0;
        end else begin
            ddx = x - mpx;
            ddy = y - mpy;
            mdx = clampv(ddx);
            mdy = clampv(ddy);
            nh = (ddx > 0) ? 1'b1 : ((ddx < 0) ? 1'b0 : mxh);
            mxr = (nh != mxh); mxh = nh;
            nh = (ddy > 0) ? 1'b1 : ((ddy < 0) ? 1'b0 : myh);
            myr = (nh != myh); myh = nh;
            if (ddx == 0 && ddy == 0) mcnt = (mcnt < STALL) ? mcnt + 1 : STALL;
            else mcnt = 0;
            mstall = (mcnt == STALL);
            mpx = x; mpy = y;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; pos_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
    endtask

    // one isolated sample; returns at the negedge where its result is visible
    task automatic drive(input int x, input int y);
        @(negedge clk);
        m_idle();
        bx = 11'(x); by = 11'(y); pos_valid = 1'b1;
        m_sample(x, y);
        @(negedge clk);
        pos_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            m_idle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; pos_valid = 1'b0; bx = 11'd0; by = 11'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs_vec() !== 14'h3000) begin
            n_bad++; $display("FAIL reset_state: got %h expected %h", obs_vec(), 14'h3000);
        end
        rst = 1'b1;
        m_reset();
        idle_cycles(1);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_heading();
        drive(60, 60);
        n_cmp++;
        if ({primed, dx, dy} !== {1'b1, 4'd0, 4'd0}) begin
            n_bad++; $display("FAIL prime: got %b %h %h expected 1 0 0", primed, dx, dy);
        end
        drive(61, 61);
        drive(62, 62);
        n_cmp++;
        if ({xh, yh, dx, dy, x_rev, y_rev} !== {1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL steady_inc: got %b expected 11_0001_0001_00", {xh, yh, dx, dy, x_rev, y_rev});
        end
        drive(61, 62);
        n_cmp++;
        if ({xh, x_rev, dx, yh, y_rev, dy} !== {1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 4'd0}) begin
            n_bad++; $display("FAIL x_reverse: got %b expected 01_1111_10_0000", {xh, x_rev, dx, yh, y_rev, dy});
        end
        idle_cycles(1);
        n_cmp++;
        if (obs_vec() !== exp_vec() || x_rev !== 1'b0) begin
            n_bad++; $display("FAIL rev_clear: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(62, 61);
        n_cmp++;
        if ({xh, x_rev, yh, y_rev} !== 4'b1101 || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL both_reverse: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        drive(100, 100);
        drive(200, 0);
        n_cmp++;
        if ({dx, dy, xh, yh} !== {4'd7, 4'b1000, 1'b1, 1'b0} || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL sat_clamp: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(0, 0);
        drive(2047, 0);
        n_cmp++;
        if (dx !== 4'sd7 || xh !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL sat_nowrap: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        apply_reset();
        drive(50, 50);
        for (int i = 1; i <= 8; i++) begin
            drive(50, 50);
            if (i == 4) idle_cycles(5);
            n_cmp++;
            if (stalled !== (i == 8) || obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL stall_count_%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        idle_cycles(3);
        n_cmp++;
        if (stalled !== 1'b1) begin
            n_bad++; $display("FAIL stall_hold: got %b expected 1", stalled);
        end
        drive(51, 50);
        n_cmp++;
        if (stalled !== 1'b0 || dx !== 4'sd1 || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL stall_clear: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(10, 10);
        drive(20, 20);
        drive(15, 25);
        #2 rst = 1'b0;
        #1;
        m_reset();
        n_cmp++;
        if (obs_vec() !== 14'h3000) begin
            n_bad++; $display("FAIL async_reset: got %h expected %h", obs_vec(), 14'h3000);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(30, 30);
        n_cmp++;
        if ({primed, dx, dy, x_rev, y_rev} !== {1'b1, 4'd0, 4'd0, 1'b0, 1'b0} || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL reprime: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(10, 5);
        @(negedge clk);
        m_idle();
        bx = 11'd10; by = 11'd5; pos_valid = 1'b1; m_sample(10, 5);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL b2b_first: got %h expected %h", obs_vec(), exp_vec());
        end
        bx = 11'd12; m_sample(12, 5);
        @(negedge clk);
        n_cmp++;
        if (dx !== 4'sd2 || x_rev !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL b2b_second: got %h expected %h", obs_vec(), exp_vec());
        end
        bx = 11'd9; m_sample(9, 5);
        @(negedge clk);
        pos_valid = 1'b0;
        n_cmp++;
        if (dx !== 4'b1101 || x_rev !== 1'b1 || xh !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL b2b_third: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int x, y, mode;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL random_cycle_%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            if ($urandom_range(0, 2) != 0) begin
                mode = $urandom_range(0, 3);
                if (mode == 0) begin
                    x = $urandom_range(0, 2047); y = $urandom_range(0, 2047);
                end else if (mode == 1) begin
                    x = mpx; y = mpy;
                end else begin
                    x = mpx + $urandom_range(0, 6) - 3; y = mpy + $urandom_range(0, 6) - 3;
                    if (x < 0) x = 0;
                    if (x > 2047) x = 2047;
                    if (y < 0) y = 0;
                    if (y > 2047) y = 2047;
                end
                bx = 11'(x); by = 11'(y); pos_valid = 1'b1;
                m_sample(x, y);
            end else begin
                pos_valid = 1'b0;
                m_idle();
            end
        end
        @(negedge clk);
        pos_valid = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL random_final: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_heading();
        test_saturation();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motion_tracker.md
Name: motion_tracker

Overview:
- Parametrised successor to the ball heading detector.
- Tracks a sprite position (bx, by) sampled on a per-frame strobe.
- Per axis it reports heading, a saturated signed velocity and a one-cycle reversal (bounce) pulse.
- Reports a global stall flag when the object stops moving. Sits between the ball-position logic and the paddle/score/sound controllers.

Parameters:
- W, 11, position width per axis (unsigned)
- DW, 4, velocity output width (signed, two's complement)
- STALL_FRAMES, 8, consecutive zero-motion samples before stalled asserts (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pos_valid  in  1  new position sample strobe (one per frame, any cycle)
- bx  in  W  ball x position
- by  in  W  ball y position
- xh  out  1  x heading: 1 = increasing, 0 = decreasing
- yh  out  1  y heading: 1 = increasing, 0 = decreasing
- dx  out  DW  signed x delta of last sample, saturated
- dy  out  DW  signed y delta of last sample, saturated
- x_rev  out  1  one-cycle pulse when xh flips
- y_rev  out  1  one-cycle pulse when yh flips
- stalled  out  1  no motion for STALL_FRAMES samples
- primed  out  1  a reference position has been captured

Behaviour:
- Reset (rst=0, asynchronous):
  - xh=1, yh=1, dx=0, dy=0, x_rev=0, y_rev=0, stalled=0, primed=0
  - prev_x=0, prev_y=0, stall count=0
  - Release is synchronous to clk.
- Sampling: all state changes only on a rising clk edge with pos_valid=1. Outputs are registered and visible in the cycle after the sampling edge (latency 1). With pos_valid=0, all outputs hold, except x_rev/y_rev, which clear to 0.
- First valid sample after reset (primed=0):
  - Capture prev_x=bx, prev_y=by and set primed=1.
  - dx, dy, xh, yh, the rev pulses and the stall count are unchanged.
- Subsequent valid samples (primed=1):
  - delta = {0,b} - {0,prev}, computed in W+1 bits signed. Never wraps.
  - dx/dy = delta saturated to [-(2^(DW-1)), 2^(DW-1)-1]. Defaults: clamp to -8..7.
  - Heading: delta>0 -> 1; delta<0 -> 0; delta==0 -> hold the previous heading.
  - Rev pulse = 1 for exactly one cycle when the new heading differs from the held heading. A zero delta never produces a pulse.
  - prev updated to the current sample.
- Stall counter:
  - On each primed valid sample, if dx==0 and dy==0, increment, saturating at STALL_FRAMES. Otherwise clear to 0.
  - stalled = (count == STALL_FRAMES), registered with the other outputs.
  - Any nonzero delta deasserts stalled on the same update.
- Back-to-back pos_valid on consecutive cycles is legal. Each is a full sample.
- Reset asserted mid-operation clears everything, including primed. The next valid sample re-primes.
- Both axes are fully independent except for stalled.

Decomposition:
- Shared package `motion_pkg`:
  - Defaults W_DEF=11, DW_DEF=4, STALL_DEF=8.
  - Localparams HEAD_INC=1'b1, HEAD_DEC=1'b0.
  - Function sat_signed(delta, DW).
- Sub-module `axis_tracker` (params W, DW), instantiated twice.
  - Inputs: clk, rst, sample_en, primed, pos.
  - Outputs: heading, delta_sat, rev, is_zero.
- Top level holds the primed flag and the stall counter (width $clog2(STALL_FRAMES+1)).

Test Plan:
1. Reset, then samples (60,60), (61,61), (62,62) -> primed=1 after the first; after the third, dx=dy=1, xh=yh=1, no rev pulses.
2. From (62,62): sample (61,62) -> xh=0, x_rev pulses one cycle, dx=-1; dy=0, yh stays 1, y_rev=0. Then sample (62,61) -> xh=1 with x_rev, yh=0 with y_rev in the same cycle.
3. Saturation: prev (100,100), sample (200,0) -> dx=7, dy=-8, xh=1, yh=0. Also 0->2047 on W=11 gives dx=7 with no wrap.
4. Stall: hold (50,50) for 8 valid samples -> stalled rises on the 8th update. Then sample (51,50) -> stalled=0, dx=1. Idle cycles without pos_valid do not advance the count.
5. Reset mid-run: after reversal activity, pulse rst low -> all outputs reset immediately (asynchronous). The next valid sample only primes; dx=0 and no rev.
6. pos_valid held high for 3 consecutive cycles with bx 10,12,9 -> dx=2 then -3, x_rev pulses once, on the last update.
